pit_host_ctrl: RTL and testbench
================================

Name: pit_host_ctrl

Overview:
- Bus initiator that drives an 8254-style timer peripheral (Di/Do, active-low CS/RD/WR, A1:A0) on behalf of internal logic.
- Converts one-word commands (program a counter; latch-and-read a counter; read a counter directly) into control-word writes and LSB/MSB data accesses with configurable setup/strobe/hold timing.
- Returns read results on a response port.
- Sits between the system sequencer or CPU shim and the timer block.

Parameters:
- SETUP_CYCLES, 1, cycles address/CS/data are valid before the strobe falls (1..255).
- STROBE_CYCLES, 2, cycles RD_n/WR_n are held low (1..255).
- HOLD_CYCLES, 1, cycles address/CS/data are held after the strobe rises (1..255).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0=PROGRAM, 1=LATCH_READ, 2=READ_DIRECT, 3=reserved (error).
- cmd_chan  in  2  counter 0..2; 3 is an error.
- cmd_rw  in  2  access format: 01=LSB only, 10=MSB only, 11=LSB then MSB.
- cmd_mode  in  3  counter mode for PROGRAM.
- cmd_bcd  in  1  BCD flag for PROGRAM.
- cmd_count  in  16  count for PROGRAM.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rsp_err  out  1  qualifies rsp_valid; high means the command was rejected.
- rsp_data  out  16  read result; 0 for PROGRAM and for errors.
- pit_di  out  8  data to the peripheral's Di.
- pit_do  in  8  data from the peripheral's Do.
- pit_cs_n, pit_rd_n, pit_wr_n  out  1 each  active-low strobes.
- pit_a0, pit_a1  out  1 each  register select.

Behaviour:
- Reset values: cs_n=rd_n=wr_n=1, a0=a1=0, pit_di=0, rsp_valid=0, rsp_err=0, rsp_data=0, cmd_ready=1. All outputs are registered.
- Reset mid-operation: the next edge returns to IDLE with all strobes high. No response is issued for the aborted command.
- Command acceptance: operands are captured at acceptance. cmd_ready drops at the acceptance edge and stays low until the response cycle.
- Rejection: cmd_op=3, cmd_chan=3, or cmd_rw=00 is rejected with no bus activity. rsp_valid=1 and rsp_err=1 in the cycle after acceptance.
- Access list for PROGRAM:
  - First, a control write to A=11 with Di={chan,rw,mode,bcd}.
  - Then data writes to A={chan} in order: rw=01 writes count[7:0]; rw=10 writes count[15:8]; rw=11 writes count[7:0] then count[15:8].
- Access list for LATCH_READ:
  - First, a control write to A=11 with Di={chan,2'b00,4'b0000}.
  - Then reads from A={chan} in the rw order.
- Access list for READ_DIRECT: the reads only, with no control write.
- Read assembly:
  - LSB read goes to rsp_data[7:0]; MSB read goes to rsp_data[15:8].
  - A byte that is not read is 0.
- Bus-cycle FSM: IDLE -> SETUP -> STROBE -> HOLD -> (next access: SETUP | done: RESP) -> IDLE.
- SETUP phase: cs_n=0, address valid, pit_di valid for writes; rd_n/wr_n=1.
- STROBE phase: wr_n=0 for writes or rd_n=0 for reads; address and data remain stable.
- Read sampling: pit_do is captured on the edge that ends the last STROBE cycle.
- HOLD phase: strobe=1; cs_n, address and data are held.
- Between accesses, control returns directly to SETUP; cs_n is not deasserted.
- RESP state (one cycle): cs_n=1, a=0, pit_di=0, rsp_valid=1, cmd_ready=1. A new command may be accepted in this same cycle.
- Latency: with N accesses and P=SETUP+STROBE+HOLD, rsp_valid is high during the cycle beginning P*N edges after acceptance (defaults: P=4).
- Counters:
  - Phase counter is 8 bits, counting down from the parameter minus 1.
  - Access index is 2 bits, maximum 3 accesses.
- Exclusivity: rd_n and wr_n are never low simultaneously. Neither strobe is low while cs_n=1.

Decomposition:
- Shared package pit_host_pkg:
  - op encodings (OP_PROGRAM, OP_LATCH_READ, OP_READ_DIRECT).
  - rw encodings (RW_LSB, RW_MSB, RW_LH).
  - A_CTRL=2'b11.
  - FSM state enum.
  - access descriptor struct {is_read, addr[1:0], data[7:0], byte_sel}.
- One sub-module pit_bus_cycle: executes a single access (SETUP/STROBE/HOLD timing, read capture) with start/done handshake.
- Top level: command decode, access list generation, response assembly.

Test Plan:
- Reset: hold reset 3 cycles, release -> cs_n/rd_n/wr_n=1, cmd_ready=1, rsp_valid=0; strobes never toggle while idle.
- PROGRAM chan0 rw=11 mode0 bin count=0x01FF -> writes (A=11,0x30), (A=00,0xFF), (A=00,0x01); wr_n low for exactly 2 cycles each; rsp_valid 12 cycles after acceptance, err=0.
- PROGRAM chan2 rw=01 mode3 count=0x000F -> writes (A=11,0x96), (A=10,0x0F); rsp_valid 8 cycles after acceptance.
- LATCH_READ chan0 rw=11, peripheral model returns 0xA5 then 0x1E -> write (A=11,0x00), two reads at A=00 -> rsp_data=0x1EA5. Repeat with READ_DIRECT rw=10 returning 0x3C -> no control write, rsp_data=0x3C00.
- Errors: cmd_chan=3, then cmd_rw=00, then cmd_op=3 -> each gives rsp_valid=1, rsp_err=1 one cycle after acceptance; cs_n stays 1 throughout.
- Back-to-back and abort: cmd_valid held high for two PROGRAMs -> second accepted in the RESP cycle. Assert reset during STROBE of the next command -> next edge wr_n=1, cs_n=1, no rsp_valid, cmd_ready=1.

Source files
------------

// File: rtl/pit_host_pkg.sv
`default_nettype none
// ============================================================================
// pit_host_pkg: encodings, state enums and access descriptor for pit_host_ctrl
// Rev 1.0
// ============================================================================
package pit_host_pkg;

  localparam logic [1:0] OP_PROGRAM     = 2'd0;
  localparam logic [1:0] OP_LATCH_READ  = 2'd1;
  localparam logic [1:0] OP_READ_DIRECT = 2'd2;

  localparam logic [1:0] RW_LSB = 2'b01;
  localparam logic [1:0] RW_MSB = 2'b10;
  localparam logic [1:0] RW_LH  = 2'b11;

  localparam logic [1:0] A_CTRL = 2'b11;

  typedef enum logic [1:0] {BUS_IDLE, BUS_SETUP, BUS_STROBE, BUS_HOLD} bus_state_e;
  typedef enum logic [1:0] {CTL_IDLE, CTL_RUN, CTL_RESP} ctl_state_e;

  // byte_sel: 0 = LSB lane, 1 = MSB lane of the 16-bit result
  typedef struct packed {
    logic       is_read;
    logic [1:0] addr;
    logic [7:0] data;
    logic       byte_sel;
  } access_t;

  function automatic logic cmd_is_bad(input logic [1:0] op, input logic [1:0] chan,
                                      input logic [1:0] rw);
    return (op == 2'd3) || (chan == 2'd3) || (rw == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pit_host_ctrl_bus_cycle.sv
`default_nettype none
// ============================================================================
// pit_bus_cycle: one timed 8254 bus access (SETUP/STROBE/HOLD) with read capture
// Rev 1.0
// ============================================================================
module pit_bus_cycle
  import pit_host_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  access_t     acc,
  input  logic [7:0]  pit_do,
  output logic        done,
  output logic [15:0] rd_lane,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic [1:0]  addr,
  output logic [7:0]  di
);

  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);

  bus_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_read_q, is_read_d;
  logic        msb_q, msb_d;
  logic        cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  di_q, di_d;
  logic [15:0] rd_lane_q, rd_lane_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_read_d = is_read_q;
    msb_d     = msb_q;
    cs_n_d    = cs_n_q;
    rd_n_d    = rd_n_q;
    wr_n_d    = wr_n_q;
    addr_d    = addr_q;
    di_d      = di_q;
    rd_lane_d = rd_lane_q;
    done      = (state_q == BUS_HOLD) && (cnt_q == 8'd0);

    case (state_q)
      BUS_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = BUS_STROBE;
          cnt_d   = STROBE_LAST;
          rd_n_d  = !is_read_q;
          wr_n_d  = is_read_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      BUS_STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = BUS_HOLD;
          cnt_d   = HOLD_LAST;
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          if (is_read_q) rd_lane_d = msb_q ? {pit_do, 8'h00} : {8'h00, pit_do};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      BUS_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = BUS_IDLE;
          cs_n_d  = 1'b1;
          addr_d  = 2'b00;
          di_d    = 8'h00;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: ;
    endcase

    // A chained access overrides the HOLD->IDLE exit so cs_n stays low
    if (start && ((state_q == BUS_IDLE) || done)) begin
      state_d   = BUS_SETUP;
      cnt_d     = SETUP_LAST;
      is_read_d = acc.is_read;
      msb_d     = acc.byte_sel;
      cs_n_d    = 1'b0;
      rd_n_d    = 1'b1;
      wr_n_d    = 1'b1;
      addr_d    = acc.addr;
      di_d      = acc.is_read ? 8'h00 : acc.data;
      rd_lane_d = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BUS_IDLE;
      cnt_q     <= 8'd0;
      is_read_q <= 1'b0;
      msb_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      addr_q    <= 2'b00;
      di_q      <= 8'h00;
      rd_lane_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_read_q <= is_read_d;
      msb_q     <= msb_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      addr_q    <= addr_d;
      di_q      <= di_d;
      rd_lane_q <= rd_lane_d;
    end
  end

  assign rd_lane = rd_lane_q;
  assign cs_n    = cs_n_q;
  assign rd_n    = rd_n_q;
  assign wr_n    = wr_n_q;
  assign addr    = addr_q;
  assign di      = di_q;

endmodule
`default_nettype wire

// File: rtl/pit_host_ctrl.sv
`default_nettype none
// ============================================================================
// pit_host_ctrl: turns timer commands into 8254 access sequences and responses
// Rev 1.0
// ============================================================================
module pit_host_ctrl
  import pit_host_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_chan,
  input  logic [1:0]  cmd_rw,
  input  logic [2:0]  cmd_mode,
  input  logic        cmd_bcd,
  input  logic [15:0] cmd_count,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_data,
  output logic [7:0]  pit_di,
  input  logic [7:0]  pit_do,
  output logic        pit_cs_n,
  output logic        pit_rd_n,
  output logic        pit_wr_n,
  output logic        pit_a0,
  output logic        pit_a1
);

  ctl_state_e        state_q, state_d;
  access_t [3:0]     list_q, list_d, new_list;
  logic [1:0]        n_q, n_d, new_n, idx_q, idx_d, idx_next;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  logic              accept, bad, is_read;
  logic [7:0]        ctrl_word;
  logic              bc_start, bc_done;
  access_t           bc_acc;
  logic [15:0]       bc_rd_lane;
  logic [1:0]        bc_addr;

  // Access list for the command currently on the input port
  always_comb begin
    accept    = cmd_valid && cmd_ready_q;
    bad       = cmd_is_bad(cmd_op, cmd_chan, cmd_rw);
    is_read   = (cmd_op == OP_LATCH_READ) || (cmd_op == OP_READ_DIRECT);
    ctrl_word = (cmd_op == OP_PROGRAM) ? {cmd_chan, cmd_rw, cmd_mode, cmd_bcd}
                                       : {cmd_chan, 6'b000000};
    new_list  = '0;
    new_n     = 2'd0;
    if (cmd_op != OP_READ_DIRECT) begin
      new_list[new_n] = '{is_read: 1'b0, addr: A_CTRL, data: ctrl_word, byte_sel: 1'b0};
      new_n = new_n + 2'd1;
    end
    if ((cmd_rw == RW_LSB) || (cmd_rw == RW_LH)) begin
      new_list[new_n] = '{is_read: is_read, addr: cmd_chan,
                          data: is_read ? 8'h00 : cmd_count[7:0], byte_sel: 1'b0};
      new_n = new_n + 2'd1;
    end
    if ((cmd_rw == RW_MSB) || (cmd_rw == RW_LH)) begin
      new_list[new_n] = '{is_read: is_read, addr: cmd_chan,
                          data: is_read ? 8'h00 : cmd_count[15:8], byte_sel: 1'b1};
      new_n = new_n + 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    list_d      = list_q;
    n_d         = n_q;
    idx_d       = idx_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    idx_next    = idx_q + 2'd1;
    bc_start    = 1'b0;
    bc_acc      = list_q[idx_next];

    case (state_q)
      CTL_RUN: begin
        if (bc_done) begin
          rsp_data_d = rsp_data_q | bc_rd_lane;
          if (idx_next < n_q) begin
            bc_start = 1'b1;
            idx_d    = idx_next;
          end else begin
            state_d     = CTL_RESP;
            rsp_valid_d = 1'b1;
            cmd_ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d     = CTL_IDLE;
        cmd_ready_d = 1'b1;
        if (accept) begin
          rsp_data_d = 16'h0000;
          if (bad) begin
            state_d     = CTL_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = CTL_RUN;
            cmd_ready_d = 1'b0;
            list_d      = new_list;
            n_d         = new_n;
            idx_d       = 2'd0;
            bc_start    = 1'b1;
            bc_acc      = new_list[0];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CTL_IDLE;
      list_q      <= '0;
      n_q         <= 2'd0;
      idx_q       <= 2'd0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      list_q      <= list_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  pit_bus_cycle #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .STROBE_CYCLES(STROBE_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) u_bus (
    .clk    (clk),
    .reset  (reset),
    .start  (bc_start),
    .acc    (bc_acc),
    .pit_do (pit_do),
    .done   (bc_done),
    .rd_lane(bc_rd_lane),
    .cs_n   (pit_cs_n),
    .rd_n   (pit_rd_n),
    .wr_n   (pit_wr_n),
    .addr   (bc_addr),
    .di     (pit_di)
  );

  assign pit_a1    = bc_addr[1];
  assign pit_a0    = bc_addr[0];
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_pit_host_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pit_host_ctrl: directed bench with bus-access and response scoreboards
// Rev 1.0
// ============================================================================
module tb_pit_host_ctrl;

  localparam int SETUP  = 1;
  localparam int STROBE = 2;
  localparam int HOLD   = 1;
  localparam int P      = SETUP + STROBE + HOLD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0, cmd_chan = 2'd0, cmd_rw = 2'd0;
  logic [2:0]  cmd_mode = 3'd0;
  logic        cmd_bcd = 1'b0;
  logic [15:0] cmd_count = 16'h0000;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_data;
  logic [7:0]  pit_di;
  logic [7:0]  pit_do = 8'h00;
  logic        pit_cs_n, pit_rd_n, pit_wr_n, pit_a0, pit_a1;

  always #5 clk = ~clk;

  pit_host_ctrl #(
    .SETUP_CYCLES (SETUP),
    .STROBE_CYCLES(STROBE),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_chan (cmd_chan),
    .cmd_rw   (cmd_rw),
    .cmd_mode (cmd_mode),
    .cmd_bcd  (cmd_bcd),
    .cmd_count(cmd_count),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_data (rsp_data),
    .pit_di   (pit_di),
    .pit_do   (pit_do),
    .pit_cs_n (pit_cs_n),
    .pit_rd_n (pit_rd_n),
    .pit_wr_n (pit_wr_n),
    .pit_a0   (pit_a0),
    .pit_a1   (pit_a1)
  );

  typedef struct {
    logic       is_read;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] data;
  } rsp_t;

  acc_t       exp_acc[$];
  logic [7:0] rd_bytes[$];
  rsp_t       rsp_q[$];

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int cs_low_seen = 0;
  bit abort_mode  = 1'b0;
  bit acc_in_resp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral-side monitor: bus protocol checks, access scoreboard, read data
  logic prev_low = 1'b0;
  logic prev_cs  = 1'b1;
  int   low_cnt  = 0;
  int   gap      = 0;
  bit   burst_first = 1'b1;

  always @(negedge clk) begin
    logic low;
    acc_t e;
    low = !pit_rd_n || !pit_wr_n;
    chk("rd_wr_exclusive", 32'(!pit_rd_n && !pit_wr_n), 32'd0);
    chk("strobe_without_cs", 32'(pit_cs_n && low), 32'd0);
    if (!pit_cs_n) cs_low_seen++;
    if (low && !prev_low) begin
      if (exp_acc.size() == 0) begin
        chk("acc_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_acc.pop_front();
        chk("acc_is_read", 32'(!pit_rd_n), 32'(e.is_read));
        chk("acc_addr", 32'({pit_a1, pit_a0}), 32'(e.addr));
        if (!e.is_read) chk("acc_wdata", 32'(pit_di), 32'(e.data));
        chk("acc_setup_len", gap, burst_first ? SETUP : HOLD + SETUP);
        if (e.is_read) begin
          if (rd_bytes.size() == 0) chk("rd_byte_missing", 32'd1, 32'd0);
          else pit_do = rd_bytes.pop_front();
        end
      end
      low_cnt     = 1;
      burst_first = 1'b0;
    end else if (low) begin
      low_cnt++;
    end
    if (!low && prev_low && !abort_mode) chk("strobe_len", low_cnt, STROBE);
    if (pit_cs_n && !prev_cs && !abort_mode) chk("hold_len", gap, HOLD);
    if (!pit_cs_n && !low) gap++;
    else gap = 0;
    if (pit_cs_n) burst_first = 1'b1;
    prev_low = low;
    prev_cs  = pit_cs_n;
  end

  // Response scoreboard
  always @(negedge clk) begin
    rsp_t r;
    if (rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_cycle", cyc, r.cyc);
        chk("rsp_err", 32'(rsp_err), 32'(r.err));
        chk("rsp_data", 32'(rsp_data), 32'(r.data));
        chk("rsp_cmd_ready", 32'(cmd_ready), 32'd1);
      end
    end
  end

  task automatic exp_wr(input logic [1:0] a, input logic [7:0] d);
    acc_t e;
    e.is_read = 1'b0;
    e.addr    = a;
    e.data    = d;
    exp_acc.push_back(e);
  endtask

  task automatic exp_rd(input logic [1:0] a, input logic [7:0] b);
    acc_t e;
    e.is_read = 1'b1;
    e.addr    = a;
    e.data    = 8'h00;
    exp_acc.push_back(e);
    rd_bytes.push_back(b);
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge
  task automatic send(input logic [1:0] op, input logic [1:0] chan, input logic [1:0] rw,
                      input logic [2:0] mode, input logic bcd, input logic [15:0] count,
                      input int n_acc, input logic err, input logic [15:0] data,
                      input bit want_rsp);
    rsp_t r;
    bit   took;
    took      = 1'b0;
    cmd_op    = op;
    cmd_chan  = chan;
    cmd_rw    = rw;
    cmd_mode  = mode;
    cmd_bcd   = bcd;
    cmd_count = count;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !took; i++) begin
      if (cmd_ready === 1'b1) begin
        acc_in_resp = (rsp_valid === 1'b1);
        if (want_rsp) begin
          r.cyc  = cyc + 1 + (err ? 0 : P * n_acc);
          r.err  = err;
          r.data = data;
          rsp_q.push_back(r);
        end
        took = 1'b1;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!took) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (rsp_q.size() != 0 && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("rsp_timeout", rsp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("in_reset_strobes", 32'({pit_cs_n, pit_rd_n, pit_wr_n}), 32'h7);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cs_n", 32'(pit_cs_n), 32'd1);
    chk("rst_rd_n", 32'(pit_rd_n), 32'd1);
    chk("rst_wr_n", 32'(pit_wr_n), 32'd1);
    chk("rst_addr", 32'({pit_a1, pit_a0}), 32'd0);
    chk("rst_di", 32'(pit_di), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("idle_strobes", 32'({pit_cs_n, pit_rd_n, pit_wr_n}), 32'h7);
    end

    // PROGRAM chan0, LSB then MSB, mode0 binary, 0x01FF
    exp_wr(2'b11, 8'h30); exp_wr(2'b00, 8'hFF); exp_wr(2'b00, 8'h01);
    send(2'd0, 2'd0, 2'b11, 3'd0, 1'b0, 16'h01FF, 3, 1'b0, 16'h0000, 1'b1);
    drain();

    // PROGRAM chan2, LSB only, mode3, 0x000F
    exp_wr(2'b11, 8'h96); exp_wr(2'b10, 8'h0F);
    send(2'd0, 2'd2, 2'b01, 3'd3, 1'b0, 16'h000F, 2, 1'b0, 16'h0000, 1'b1);
    drain();

    // LATCH_READ chan0, LSB then MSB
    exp_wr(2'b11, 8'h00); exp_rd(2'b00, 8'hA5); exp_rd(2'b00, 8'h1E);
    send(2'd1, 2'd0, 2'b11, 3'd0, 1'b0, 16'h0000, 3, 1'b0, 16'h1EA5, 1'b1);
    drain();

    // READ_DIRECT chan1, MSB only
    exp_rd(2'b01, 8'h3C);
    send(2'd2, 2'd1, 2'b10, 3'd0, 1'b0, 16'h0000, 1, 1'b0, 16'h3C00, 1'b1);
    drain();

    // Rejected commands: bad channel, bad rw, reserved op
    cs_low_seen = 0;
    send(2'd0, 2'd3, 2'b11, 3'd0, 1'b0, 16'h1234, 0, 1'b1, 16'h0000, 1'b1);
    drain();
    send(2'd1, 2'd0, 2'b00, 3'd0, 1'b0, 16'h0000, 0, 1'b1, 16'h0000, 1'b1);
    drain();
    send(2'd3, 2'd0, 2'b11, 3'd0, 1'b0, 16'h0000, 0, 1'b1, 16'h0000, 1'b1);
    drain();
    chk("err_cs_stays_high", cs_low_seen, 32'd0);

    // Back-to-back PROGRAMs with cmd_valid held high
    exp_wr(2'b11, 8'h65); exp_wr(2'b01, 8'hAB);
    exp_wr(2'b11, 8'h12); exp_wr(2'b00, 8'h34);
    send(2'd0, 2'd1, 2'b10, 3'd2, 1'b1, 16'hABCD, 2, 1'b0, 16'h0000, 1'b1);
    send(2'd0, 2'd0, 2'b01, 3'd1, 1'b0, 16'h1234, 2, 1'b0, 16'h0000, 1'b1);
    chk("b2b_accept_in_resp", 32'(acc_in_resp), 32'd1);
    drain();

    // Abort with reset during the STROBE of the control write
    exp_wr(2'b11, 8'hB0);
    send(2'd0, 2'd2, 2'b11, 3'd0, 1'b0, 16'h5555, 3, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("abort_in_strobe", 32'(pit_wr_n), 32'd0);
    abort_mode = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wr_n", 32'(pit_wr_n), 32'd1);
    chk("abort_cs_n", 32'(pit_cs_n), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_abort_idle", 32'({pit_cs_n, pit_rd_n, pit_wr_n}), 32'h7);
    abort_mode = 1'b0;

    chk("acc_queue_empty", exp_acc.size(), 32'd0);
    chk("rd_queue_empty", rd_bytes.size(), 32'd0);
    chk("rsp_queue_empty", rsp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
